uart_rx_ctrl: RTL

Command sequencer behind the UART receiver. It consumes the receiver's byte strobes (data, parity error, stop error), parses them into register-write and receiver-configuration commands, and drives the receiver's parity-enable, parity-type and prescale inputs. It sits between the UART_RX instance and the system register file, so the UART link is the register file's write master.

---
 rtl/uart_rx_ctrl_if.sv | 31 +++
 rtl/uart_rx_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receiver/host side and the uart_rx_ctrl command sequencer.
// master: receiver side (drives byte strobes); slave: the sequencer.
interface uart_rx_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        rx_p_data;
  logic              rx_data_valid;
  logic              rx_par_err;
  logic              rx_stp_err;
  logic              cfg_par_en;
  logic              cfg_par_typ;
  logic [5:0]        cfg_prescale;
  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wr_data;
  logic              busy;
  logic              err_pulse;
  logic [7:0]        err_cnt;

  modport master (
    output rx_p_data, rx_data_valid, rx_par_err, rx_stp_err,
    input  cfg_par_en, cfg_par_typ, cfg_prescale,
    input  reg_wr_en, reg_addr, reg_wr_data, busy, err_pulse, err_cnt
  );

  modport slave (
    input  rx_p_data, rx_data_valid, rx_par_err, rx_stp_err,
    output cfg_par_en, cfg_par_typ, cfg_prescale,
    output reg_wr_en, reg_addr, reg_wr_data, busy, err_pulse, err_cnt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART byte-stream command sequencer: register writes (A5,addr,data) and rx config (5A,cfg).
// Optional `RX_CTRL_CHKSUM_EN adds a trailing checksum byte (A5^addr^data) to write commands.
module uart_rx_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

`ifdef RX_CTRL_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, CFG_DATA, WR_CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, CFG_DATA} state_t;
`endif

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_par_en;
  logic              r_par_typ;
  logic [5:0]        r_prescale;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_err;
  logic [7:0]        r_err_cnt;
`ifdef RX_CTRL_CHKSUM_EN
  logic [7:0]        r_addr_b;
  logic              w_chk_ok;
`endif

  logic       w_ok;
  logic       w_bad;
  logic       w_timeout;
  logic       w_err;
  logic [1:0] w_sel;

  assign w_ok      = bus.rx_data_valid & ~bus.rx_par_err & ~bus.rx_stp_err;
  assign w_bad     = bus.rx_data_valid & (bus.rx_par_err | bus.rx_stp_err);
  assign w_sel     = bus.rx_p_data[3:2];
  // A strobe in the expiry cycle suppresses the timeout.
  assign w_timeout = ~bus.rx_data_valid && (r_state != IDLE) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`ifdef RX_CTRL_CHKSUM_EN
  assign w_chk_ok  = (bus.rx_p_data == (8'hA5 ^ r_addr_b ^ r_wdata));
`endif

  always_comb begin
    w_err = w_bad | w_timeout;
    if (w_ok) begin
      case (r_state)
        IDLE:     w_err = (bus.rx_p_data != 8'hA5) && (bus.rx_p_data != 8'h5A);
        CFG_DATA: w_err = (w_sel == 2'b11);
`ifdef RX_CTRL_CHKSUM_EN
        WR_CHK:   w_err = ~w_chk_ok;
`endif
        default:  w_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_prescale <= 6'd8;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
`ifdef RX_CTRL_CHKSUM_EN
      r_addr_b   <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= w_err;
      if (w_err && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;

      if (bus.rx_data_valid || w_timeout)
        r_cnt <= '0;
      else if (r_state != IDLE)
        r_cnt <= r_cnt + 1'b1;

      if (w_bad || w_timeout) begin
        r_state <= IDLE;
      end else if (w_ok) begin
        case (r_state)
          IDLE: begin
            if (bus.rx_p_data == 8'hA5)      r_state <= WR_ADDR;
            else if (bus.rx_p_data == 8'h5A) r_state <= CFG_DATA;
          end
          WR_ADDR: begin
            r_addr  <= bus.rx_p_data[ADDR_W-1:0];
`ifdef RX_CTRL_CHKSUM_EN
            r_addr_b <= bus.rx_p_data;
`endif
            r_state <= WR_DATA;
          end
          WR_DATA: begin
            r_wdata <= bus.rx_p_data;
`ifdef RX_CTRL_CHKSUM_EN
            r_state <= WR_CHK;
`else
            r_wr_en <= 1'b1;
            r_state <= IDLE;
`endif
          end
`ifdef RX_CTRL_CHKSUM_EN
          WR_CHK: begin
            r_wr_en <= w_chk_ok;
            r_state <= IDLE;
          end
`endif
          CFG_DATA: begin
            if (w_sel != 2'b11) begin
              r_par_en   <= bus.rx_p_data[0];
              r_par_typ  <= bus.rx_p_data[1];
              r_prescale <= 6'd8 << w_sel;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_par_en   = r_par_en;
  assign bus.cfg_par_typ  = r_par_typ;
  assign bus.cfg_prescale = r_prescale;
  assign bus.reg_wr_en    = r_wr_en;
  assign bus.reg_addr     = r_addr;
  assign bus.reg_wr_data  = r_wdata;
  assign bus.busy         = (r_state != IDLE);
  assign bus.err_pulse    = r_err;
  assign bus.err_cnt      = r_err_cnt;
endmodule
